// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master link: opcodes, frame sizes and the
// controller state encoding (also used by the slave verification model).
package spi_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_GAP     = 3'd4
    } spi_state_e;

    function automatic logic [1:0] cmd_opcode(input logic [FRAME_BITS-1:0] word);
        return word[FRAME_BITS-1 -: 2];
    endfunction

endpackage

// File: rtl/spi_master_shreg.sv
// Frame shifter for the SPI master: parallel-load 10-bit transmit register
// with MSB serial out, plus an 8-bit MSB-first serial-in capture register.
module spi_master_shreg
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  capture,
    input  logic [FRAME_BITS-1:0] load_word,
    input  logic                  miso,
    output logic                  mosi_bit,
    output logic [DATA_BITS-1:0]  cap_data
);

    logic [FRAME_BITS-1:0] tx_r;
    logic [DATA_BITS-1:0]  rx_r;

    // Transmit register: load wins over shift, zeros fill from the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r <= '0;
        end else if (load) begin
            tx_r <= load_word;
        end else if (shift) begin
            tx_r <= {tx_r[FRAME_BITS-2:0], 1'b0};
        end
    end

    // Capture register: first sampled bit ends up in the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_r <= '0;
        end else if (capture) begin
            rx_r <= {rx_r[DATA_BITS-2:0], miso};
        end
    end

    assign mosi_bit = tx_r[FRAME_BITS-1];
    assign cap_data = rx_r;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: serialises 10-bit commands, captures read replies.
// Optional read-sequence check enabled by defining SPI_MASTER_SEQ_CHECK_EN.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FRAME_BITS-1:0] cmd_word,
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  rd_valid,
    output logic [DATA_BITS-1:0]  rd_data,
    output logic                  busy,
    output logic                  err
);

    spi_state_e           state_r, state_s;
    logic [3:0]           cnt_r, cnt_s;
    logic                 rd_frame_r;
    logic                 load_s, shift_s, cap_s, accept_s, seq_err_s, first_gap_s;
    logic                 ss_n_r, mosi_r, rd_valid_r;
    logic [DATA_BITS-1:0] rd_data_r;
    logic                 mosi_bit_s;
    logic [DATA_BITS-1:0] cap_data_s;

    assign accept_s    = (state_r == ST_IDLE) && cmd_valid;
    assign first_gap_s = (state_r == ST_GAP) && (cnt_r == 4'd0);

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic rd_pend_r, err_r;

    assign seq_err_s = (cmd_opcode(cmd_word) == OP_RD_DATA) && !rd_pend_r;

    // Read-pending flag: armed by rd-addr, consumed by rd-data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            err_r <= accept_s && seq_err_s;
            if (accept_s && (cmd_opcode(cmd_word) == OP_RD_ADDR)) begin
                rd_pend_r <= 1'b1;
            end else if (accept_s && (cmd_opcode(cmd_word) == OP_RD_DATA)) begin
                rd_pend_r <= 1'b0;
            end
        end
    end

    assign err = err_r;
`else
    assign seq_err_s = 1'b0;
    assign err       = 1'b0;
`endif

    // State, shared phase counter and frame-type register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            rd_frame_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                rd_frame_r <= (cmd_opcode(cmd_word) == OP_RD_DATA) && !seq_err_s;
            end
        end
    end

    // Next-state decode; the counter restarts at every phase change.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + 4'd1;
        load_s  = 1'b0;
        shift_s = 1'b0;
        cap_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 4'd0;
                if (cmd_valid) begin
                    load_s  = 1'b1;
                    state_s = seq_err_s ? ST_GAP : ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == 4'(FRAME_BITS - 1)) begin
                    cnt_s   = 4'd0;
                    state_s = rd_frame_r ? ST_WAIT_RD : ST_GAP;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_WAIT_RD: begin
                if (cnt_r == 4'(RD_LATENCY - 1)) begin
                    cnt_s   = 4'd0;
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_WAIT_RD;
                end
            end
            ST_CAPTURE: begin
                cap_s = 1'b1;
                if (cnt_r == 4'(DATA_BITS - 1)) begin
                    cnt_s   = 4'd0;
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_GAP: begin
                // Outputs lag state by a cycle, so one extra cycle keeps SS_n high long enough.
                if (cnt_r == 4'(GAP_CYCLES)) begin
                    cnt_s   = 4'd0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                cnt_s   = 4'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered pin and read-result outputs, decoded from the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_r     <= 1'b1;
            mosi_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            ss_n_r     <= !((state_r == ST_SHIFT) || (state_r == ST_WAIT_RD) ||
                            (state_r == ST_CAPTURE));
            mosi_r     <= (state_r == ST_SHIFT) && mosi_bit_s;
            rd_valid_r <= first_gap_s && rd_frame_r;
            if (first_gap_s && rd_frame_r) begin
                rd_data_r <= cap_data_s;
            end
        end
    end

    spi_master_shreg u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .shift     (shift_s),
        .capture   (cap_s),
        .load_word (cmd_word),
        .miso      (MISO),
        .mosi_bit  (mosi_bit_s),
        .cap_data  (cap_data_s)
    );

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign SS_n      = ss_n_r;
    assign MOSI      = mosi_r;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Single-clock SPI master that drives the RAM-side SPI slave link. It accepts 10-bit command words (2-bit opcode plus 8-bit address or data) on a valid/ready interface and serialises them MSB-first on MOSI under SS_n. For read-data commands it captures the 8-bit reply from MISO and returns it on a one-cycle valid strobe. It sits between the host/test sequencer and the SPI slave + RAM subsystem.

## Interface
- RD_LATENCY, 3: cycles after the last MOSI bit of a read-data frame before the first MISO bit is sampled (legal 1..15).
- GAP_CYCLES, 1: minimum cycles SS_n is held high between frames (legal 1..7).
- clk  in  1  system clock; the slave samples MOSI and the master samples MISO on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command word present.
- cmd_ready  out  1  master can accept a command; high only in IDLE.
- cmd_word  in  10  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.
- rd_valid  out  1  one-cycle strobe; rd_data is valid.
- rd_data  out  8  captured read byte, held until the next capture.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  one-cycle sequence-error strobe (see Configuration).

## Operation
- States: IDLE, SHIFT, WAIT_RD, CAPTURE, GAP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: load cmd_word into the shift register, clear the bit counter, go to SHIFT.
- SHIFT: SS_n=0; MOSI=cmd_word[9-k] on the k-th SHIFT cycle, k=0..9. After k=9: opcode 11 goes to WAIT_RD; otherwise goes to GAP.
- WAIT_RD: SS_n=0, MOSI=0 for RD_LATENCY cycles, then go to CAPTURE.
- CAPTURE: SS_n=0; sample MISO on 8 consecutive cycles, MSB first, into rd_data[7-j]. After j=7, go to GAP; rd_valid=1 in the first GAP cycle.
- GAP: SS_n=1, MOSI=0 for GAP_CYCLES cycles, then go to IDLE.
- The read-pending flag sets on an accepted opcode 10 and clears on an accepted opcode 11. It is used only when the sequence check is enabled.
- Reset (any state, including mid-frame): go to IDLE; SS_n=1, MOSI=0, rd_valid=0, rd_data=0, err=0, busy=0, cmd_ready=1, read-pending=0. A partially sent frame is abandoned, and the slave returns to its idle state on SS_n high.
- cmd_valid while busy is ignored. The command is not queued.

## Timing
- Accept at edge N: SS_n falls and MOSI=cmd_word[9] at edge N+1; the last bit is at N+10.
- Write / rd-addr frame: SS_n low for exactly 10 cycles. The next accept is possible GAP_CYCLES+1 cycles after SS_n rises.
- Rd-data frame: SS_n low for 10+RD_LATENCY+8 cycles. rd_valid asserts 1 cycle after the last MISO sample.
- Command-to-rd_valid latency = 10+RD_LATENCY+8+1 cycles after the accept edge.
- All outputs are registered except cmd_ready and busy, which are decoded from the state register.

## Configuration
- SPI_MASTER_SEQ_CHECK_EN defined:
  - An opcode-11 command accepted while read-pending=0 is not transmitted.
  - SS_n stays high, err pulses for 1 cycle, and the state goes to GAP. rd_valid does not assert.
- Not defined: opcode 11 is always transmitted, err is tied to 0, and read-pending logic is removed.

## Structure
- Package spi_pkg:
  - Opcode constants OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA.
  - FRAME_BITS=10, DATA_BITS=8.
  - State encoding, shared with the slave's verification model.
- One sub-module, spi_master_shreg: 10-bit parallel-load shift register with MSB serial out and 8-bit serial-in capture, with load, shift and capture enables. The FSM and counters stay in spi_master_ctrl.

## Test plan
- Reset then wr-addr: cmd_word=10'h0A5 -> SS_n low 10 cycles, MOSI=0,0,1,0,1,0,0,1,0,1. rd_valid, err and rd_data stay 0.
- Read sequence: rd-addr 10'h2_3C, then rd-data 10'h3_00, with the slave model driving 8'hC3 on MISO after RD_LATENCY=3 -> rd_valid pulse 22 cycles after the second accept, rd_data=8'hC3.
- Back-to-back: cmd_valid held high with two wr-data words -> the second is accepted exactly GAP_CYCLES+1 cycles after SS_n rises, and cmd_ready=0 throughout frame 1.
- Reset mid-frame: assert rst_n=0 at bit 5 of SHIFT -> SS_n=1 and MOSI=0 immediately, busy=0. A fresh command afterwards is sent intact.
- Sequence check with SPI_MASTER_SEQ_CHECK_EN: rd-data without a prior rd-addr -> err one pulse, SS_n never falls, no rd_valid. Without the macro, the frame is sent and err stays 0.
- rd_data hold: after a capture of 8'h5A, run a write frame -> rd_data stays 8'h5A and rd_valid stays 0.
